i2s_tx_sched: RTL

- Stereo sample scheduler in front of the I2S transmitter.
- Pulls left-channel and right-channel samples from two independent valid/ready streams and presents them as one strictly alternating L,R,L,R stream on the transmitter's single sample input.
- Keeps L/R framing intact on source underflow by substituting a fill sample, and counts underflows.
- Runs in the I2S clock domain, between the per-channel async FIFOs and the transmitter.

---
 rtl/i2s_pkg.sv | 27 ++
 rtl/i2s_tx_sched_sat_counter.sv | 38 +++
 rtl/i2s_tx_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit sample scheduler.
// Optional build macro used by i2s_tx_sched: I2S_SCHED_HOLD_LAST_EN.
package i2s_pkg;

    // Default sample width in bits
    localparam int unsigned DEFAULT_DW = 24;

    // Channel tag carried alongside each sample
    localparam logic CHAN_L = 1'b0;
    localparam logic CHAN_R = 1'b1;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_FETCH_L = 3'd2,
        ST_SEND_L  = 3'd3,
        ST_FETCH_R = 3'd4,
        ST_SEND_R  = 3'd5
    } sched_state_t;

    // True for the states that present a sample to the transmitter
    function automatic logic is_send_state(input sched_state_t st);
        return (st == ST_SEND_L) || (st == ST_SEND_R);
    endfunction

endpackage : i2s_pkg

// File: rtl/i2s_tx_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, then increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/i2s_tx_sched.sv
// Stereo scheduler: merges independent L and R sample streams into one
// strictly alternating L,R stream for the I2S transmitter, substituting a
// fill sample when a channel source underflows while the transmitter waits.
// Build macro I2S_SCHED_HOLD_LAST_EN: fill repeats the last delivered sample
// of that channel; otherwise fill is zero (mute).
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int unsigned DW    = DEFAULT_DW,
    parameter int unsigned UF_CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_uf_clear,
    input  logic             i_l_valid,
    output logic             o_l_ready,
    input  logic [DW-1:0]    i_l_sample,
    input  logic             i_r_valid,
    output logic             o_r_ready,
    input  logic [DW-1:0]    i_r_sample,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DW-1:0]    o_sample,
    output logic             o_chan,
    output logic             o_underflow,
    output logic [UF_CW-1:0] o_uf_count
);

    sched_state_t   state_q, state_d;
    logic [DW-1:0]  sample_q, sample_d;
    logic           chan_q, chan_d;
    logic           valid_q, valid_d;
    logic           l_ready_q, l_ready_d;
    logic           r_ready_q, r_ready_d;
    logic           uf_q, uf_d;
    logic           l_xfer, r_xfer;
    logic [DW-1:0]  fill_l, fill_r;

`ifdef I2S_SCHED_HOLD_LAST_EN
    logic [DW-1:0]  hold_l_q, hold_r_q;

    // Remember the last sample actually taken from each stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
        end else begin
            if (l_xfer) begin
                hold_l_q <= i_l_sample;
            end
            if (r_xfer) begin
                hold_r_q <= i_r_sample;
            end
        end
    end

    assign fill_l = hold_l_q;
    assign fill_r = hold_r_q;
`else
    assign fill_l = DW'(0);
    assign fill_r = DW'(0);
`endif

    // Next state, captured sample and underflow event
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        chan_d   = chan_q;
        uf_d     = 1'b0;
        l_xfer   = 1'b0;
        r_xfer   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_PRIME;
                end
            end

            // Wait for the first L sample; never substitute here
            ST_PRIME: begin
                if (i_l_valid) begin
                    l_xfer   = 1'b1;
                    sample_d = i_l_sample;
                    chan_d   = CHAN_L;
                    state_d  = ST_SEND_L;
                end else if (!i_enable) begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH_L: begin
                chan_d = CHAN_L;
                if (i_l_valid) begin
                    l_xfer   = 1'b1;
                    sample_d = i_l_sample;
                    state_d  = ST_SEND_L;
                end else if (i_ready) begin
                    uf_d     = 1'b1;
                    sample_d = fill_l;
                    state_d  = ST_SEND_L;
                end
            end

            ST_SEND_L: begin
                if (i_ready) begin
                    state_d = ST_FETCH_R;
                end
            end

            ST_FETCH_R: begin
                chan_d = CHAN_R;
                if (i_r_valid) begin
                    r_xfer   = 1'b1;
                    sample_d = i_r_sample;
                    state_d  = ST_SEND_R;
                end else if (i_ready) begin
                    uf_d     = 1'b1;
                    sample_d = fill_r;
                    state_d  = ST_SEND_R;
                end
            end

            // A pair only ends after R, so disabling never orphans an L
            ST_SEND_R: begin
                if (i_ready) begin
                    state_d = i_enable ? ST_FETCH_L : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d   = is_send_state(state_d);
        l_ready_d = (state_d == ST_PRIME) || (state_d == ST_FETCH_L);
        r_ready_d = (state_d == ST_FETCH_R);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sample_q  <= '0;
            chan_q    <= 1'b0;
            valid_q   <= 1'b0;
            l_ready_q <= 1'b0;
            r_ready_q <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            l_ready_q <= l_ready_d;
            r_ready_q <= r_ready_d;
            uf_q      <= uf_d;
        end
    end

    // Underflow counter, bumped in the same cycle the fill is captured
    sat_counter #(
        .W (UF_CW)
    ) u_uf_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (i_uf_clear),
        .inc_i   (uf_d),
        .count_o (o_uf_count)
    );

    assign o_valid     = valid_q;
    assign o_l_ready   = l_ready_q;
    assign o_r_ready   = r_ready_q;
    assign o_sample    = sample_q;
    assign o_chan      = chan_q;
    assign o_underflow = uf_q;

endmodule : i2s_tx_sched
